// File: rtl/sram_port_arbiter.sv
// Registered round-robin owner of the single SRAM port shared by fill (0), alpha blend (1)
// and display scan-out (2). Grants are held per burst, and a hold limit prevents starvation.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned DATA_W   = 1536,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [2:0]            req,
    input  logic [2:0]            lock,
    input  logic [2:0]            req_re,
    input  logic [2:0]            req_we,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rd_valid,
    output logic                  read_enable,
    output logic                  write_enable,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W-1:0]     write_data,
    output logic                  busy,
    output logic                  conflict
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state;
    logic [1:0]          owner;
    logic [1:0]          last;
    logic [7:0]          hold_cnt;

    logic                own_req;
    logic                own_lock;
    logic                own_re;
    logic                own_we;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic [2:0]          own_oh;
    logic                fwd;
    logic                others;
    logic                hold_hit;
    logic [1:0]          pick;

    // First requester after `l` in round-robin order; nearest candidate is tested last so it wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
        logic [1:0]  p;
        int unsigned idx;
        p = 2'd0;
        for (int unsigned k = 3; k >= 1; k--) begin
            idx = (32'(l) + k) % 32'd3;
            if (r[2'(idx)]) p = 2'(idx);
        end
        return p;
    endfunction

    assign busy = (state == OWN);

    // Owner selection and SRAM forwarding, gated so only a requesting owner reaches the pins.
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_re    = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        own_oh    = 3'b000;
        for (int unsigned i = 0; i < 3; i++) begin
            if (owner == 2'(i)) begin
                own_req   = req[i];
                own_lock  = lock[i];
                own_re    = req_re[i];
                own_we    = req_we[i];
                own_addr  = req_addr[i*ADDR_W +: ADDR_W];
                own_wdata = req_wdata[i*DATA_W +: DATA_W];
                own_oh    = 3'(3'b001 << i);
            end
        end
        fwd          = busy & own_req & n_rst;
        others       = |(req & ~own_oh);
        hold_hit     = (hold_cnt == HOLD_MAX) & others & ~own_lock;
        pick         = rr_pick(req, last);
        write_enable = fwd & own_we;
        read_enable  = fwd & own_re & ~own_we;
        address      = fwd ? own_addr : '0;
        write_data   = fwd ? own_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last     <= 2'd2;
            hold_cnt <= 8'd0;
            gnt      <= 3'b000;
            rd_valid <= 3'b000;
            conflict <= 1'b0;
        end else begin
            // Read ownership follows the strobe even if the grant drops next cycle.
            rd_valid <= read_enable ? own_oh : 3'b000;
            if (fwd & own_re & own_we) conflict <= 1'b1;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= OWN;
                        owner    <= pick;
                        gnt      <= 3'b001 << pick;
                        hold_cnt <= 8'd1;
                    end
                end
                OWN: begin
                    if (!own_req || hold_hit) begin
                        state    <= IDLE;
                        gnt      <= 3'b000;
                        last     <= owner;
                        hold_cnt <= 8'd0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: round-robin order, reads, hold limit, lock,
// strobe collision and reset mid-burst, each checked against hand-derived values.
module tb_sram_port_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 64;
    localparam int unsigned MH = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic [2:0]        req;
    logic [2:0]        lock;
    logic [2:0]        req_re;
    logic [2:0]        req_we;
    logic [3*AW-1:0]   req_addr;
    logic [3*DW-1:0]   req_wdata;
    logic [2:0]        gnt;
    logic [2:0]        rd_valid;
    logic              read_enable;
    logic              write_enable;
    logic [AW-1:0]     address;
    logic [DW-1:0]     write_data;
    logic              busy;
    logic              conflict;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [2:0]        exp_oh;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req          (req),
        .lock         (lock),
        .req_re       (req_re),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rd_valid     (rd_valid),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .busy         (busy),
        .conflict     (conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0; req = 3'b000; lock = 3'b000; req_re = 3'b000; req_we = 3'b000;
        req_addr = '0; req_wdata = '0;
        nxt(); nxt();
        chk("rst_gnt",      64'(gnt),          64'h0);
        chk("rst_rd_valid", 64'(rd_valid),     64'h0);
        chk("rst_busy",     64'(busy),         64'h0);
        chk("rst_conflict", 64'(conflict),     64'h0);
        chk("rst_re",       64'(read_enable),  64'h0);
        chk("rst_we",       64'(write_enable), 64'h0);
        chk("rst_addr",     64'(address),      64'h0);
        n_rst = 1'b1;

        // All three requesting; each owner drops after 3 grant cycles: 001, 010, 100, 001.
        for (int r = 0; r < 4; r++) begin
            exp_oh = 3'b001 << (r % 3);
            req = 3'b111;
            #1 chk("rr_idle", 64'(gnt), 64'h0);
            nxt();
            for (int c = 0; c < 3; c++) begin
                req = (c == 2) ? (3'b111 & ~exp_oh) : 3'b111;
                #1 chk("rr_gnt", 64'(gnt), 64'(exp_oh));
                nxt();
            end
        end
        req = 3'b000;
        #1 chk("rr_idle_end", 64'(gnt), 64'h0);

        // Fill reads 0x10 then 0x11 back to back.
        req = 3'b001;
        nxt();
        req_re = 3'b001; req_addr[0 +: AW] = 24'h000010;
        #1 chk("rd0_gnt",  64'(gnt),          64'h1);
        chk("rd0_re",      64'(read_enable),  64'h1);
        chk("rd0_we",      64'(write_enable), 64'h0);
        chk("rd0_addr",    64'(address),      64'h10);
        nxt();
        req_addr[0 +: AW] = 24'h000011;
        #1 chk("rd1_re",   64'(read_enable),  64'h1);
        chk("rd1_addr",    64'(address),      64'h11);
        chk("rd1_valid",   64'(rd_valid),     64'h1);
        nxt();
        req = 3'b000; req_re = 3'b000;
        #1 chk("rd2_valid", 64'(rd_valid),    64'h1);
        chk("rd2_re",      64'(read_enable),  64'h0);
        chk("rd2_addr",    64'(address),      64'h0);
        nxt();
        #1 chk("rd3_gnt",  64'(gnt),          64'h0);
        chk("rd3_valid",   64'(rd_valid),     64'h0);

        // Hold limit of 4: alpha forced off while scan waits; its last read lands after the grant.
        req = 3'b010;
        nxt();
        req = 3'b110;
        #1 chk("hl_gnt0",  64'(gnt),  64'h2);
        chk("hl_busy",     64'(busy), 64'h1);
        nxt();
        #1 chk("hl_gnt1",  64'(gnt), 64'h2);
        nxt();
        #1 chk("hl_gnt2",  64'(gnt), 64'h2);
        nxt();
        req_re = 3'b010; req_addr[AW +: AW] = 24'h000020;
        #1 chk("hl_gnt3",  64'(gnt),         64'h2);
        chk("hl_re3",      64'(read_enable), 64'h1);
        chk("hl_addr3",    64'(address),     64'h20);
        nxt();
        #1 chk("hl_drop",  64'(gnt),         64'h0);
        chk("hl_idle",     64'(busy),        64'h0);
        chk("hl_rdv",      64'(rd_valid),    64'h2);
        chk("hl_no_fwd",   64'(read_enable), 64'h0);
        chk("hl_no_addr",  64'(address),     64'h0);
        nxt();
        req_re = 3'b000; req = 3'b000;
        #1 chk("hl_scan",  64'(gnt),      64'h4);
        chk("hl_rdv_none", 64'(rd_valid), 64'h0);
        nxt();
        #1 chk("hl_end",   64'(gnt), 64'h0);

        // Locked alpha keeps the port for 20 cycles despite scan waiting.
        lock = 3'b010; req = 3'b010;
        nxt();
        for (int i = 0; i < 20; i++) begin
            req = (i == 19) ? 3'b100 : 3'b110;
            #1 chk("lk_gnt", 64'(gnt), 64'h2);
            nxt();
        end
        lock = 3'b000;
        #1 chk("lk_drop", 64'(gnt), 64'h0);
        nxt();

        // Scan strobes read and write together; alpha's read strobe is ignored.
        req_re = 3'b110; req_we = 3'b100;
        req_addr[2*AW +: AW] = 24'hABCDEF;
        req_addr[AW +: AW]   = 24'h000777;
        req_wdata[2*DW +: DW] = 64'h0123456789ABCDEF;
        #1 chk("cf_gnt",   64'(gnt),          64'h4);
        chk("cf_we",       64'(write_enable), 64'h1);
        chk("cf_re",       64'(read_enable),  64'h0);
        chk("cf_addr",     64'(address),      64'hABCDEF);
        chk("cf_wdata",    64'(write_data),   64'h0123456789ABCDEF);
        chk("cf_pre",      64'(conflict),     64'h0);
        nxt();
        req_re = 3'b000; req_we = 3'b000; req = 3'b000;
        #1 chk("cf_set",   64'(conflict), 64'h1);
        chk("cf_rdv",      64'(rd_valid), 64'h0);
        nxt();
        #1 chk("cf_gnt_off", 64'(gnt),     64'h0);
        chk("cf_sticky1",  64'(conflict), 64'h1);
        nxt();
        #1 chk("cf_sticky2", 64'(conflict), 64'h1);

        // Reset during an alpha burst with a read in flight.
        req = 3'b010;
        nxt();
        req_re = 3'b010; req_addr[AW +: AW] = 24'h000055;
        #1 chk("mr_gnt",   64'(gnt),         64'h2);
        chk("mr_re",       64'(read_enable), 64'h1);
        nxt();
        n_rst = 1'b0;
        #1 chk("mr_rdv_pre", 64'(rd_valid), 64'h2);
        nxt();
        #1 chk("mr_gnt0",  64'(gnt),          64'h0);
        chk("mr_rdv0",     64'(rd_valid),     64'h0);
        chk("mr_re0",      64'(read_enable),  64'h0);
        chk("mr_we0",      64'(write_enable), 64'h0);
        chk("mr_addr0",    64'(address),      64'h0);
        chk("mr_wdata0",   64'(write_data),   64'h0);
        chk("mr_busy0",    64'(busy),         64'h0);
        chk("mr_conf0",    64'(conflict),     64'h0);
        n_rst = 1'b1; req = 3'b011; req_re = 3'b000;
        nxt();
        #1 chk("mr_fill_first", 64'(gnt), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
